// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control sequencer for the single-bus CPU: fetch, decode and
// execute of MOVE/MOVI/ALU/ALUI/HALT with an MFC timeout and sticky status flags.
module cpu_seq_ctrl #(
  parameter int DATA_W      = 16,
  parameter int OPC_W       = 4,
  parameter int NUM_REGS    = 4,
  parameter int MFC_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   instr,
  input  logic                mfc,
  output logic                pc_read,
  output logic                pc_increment,
  output logic                mar_write,
  output logic                mar_mem_read,
  output logic                mem_en,
  output logic                mem_rw,
  output logic                mdr_mem_write,
  output logic                mdr_read,
  output logic                ir_write,
  output logic [NUM_REGS-1:0] reg_read,
  output logic [NUM_REGS-1:0] reg_write,
  output logic                imm_en,
  output logic [DATA_W-1:0]   imm_out,
  output logic [2:0]          alu_op,
  output logic                alu_in1_we,
  output logic                alu_in2_we,
  output logic                alu_out_en,
  output logic                instr_done,
  output logic                halted,
  output logic                illegal,
  output logic                bus_error,
  output logic [3:0]          fsm_state
);

  localparam int FLD_W = (DATA_W - OPC_W) / 2;
  localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MFC_TIMEOUT - 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_F1   = 4'd1;
  localparam logic [3:0] S_F2   = 4'd2;
  localparam logic [3:0] S_F3   = 4'd3;
  localparam logic [3:0] S_DEC  = 4'd4;
  localparam logic [3:0] S_MV   = 4'd5;
  localparam logic [3:0] S_MI   = 4'd6;
  localparam logic [3:0] S_A1   = 4'd7;
  localparam logic [3:0] S_A2   = 4'd8;
  localparam logic [3:0] S_A3   = 4'd9;
  localparam logic [3:0] S_HLT  = 4'd10;
  localparam logic [3:0] S_ERR  = 4'd11;

  localparam logic [OPC_W-1:0] OP_MOVE = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_MOVI = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(4'hF);

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [OPC_W-1:0]  opcode;
  logic [FLD_W-1:0]  ri;
  logic [FLD_W-1:0]  rj;
  logic [DATA_W-1:0] imm_val;
  logic              is_move, is_movi, is_alu, is_alui, is_halt;
  logic              ri_bad, rj_bad, dec_illegal, mfc_expire;

  assign opcode  = instr[DATA_W-1 -: OPC_W];
  assign ri      = instr[2*FLD_W-1 -: FLD_W];
  assign rj      = instr[FLD_W-1:0];
  assign imm_val = {{(DATA_W-FLD_W){1'b0}}, rj};

  assign is_move = (opcode == OP_MOVE);
  assign is_movi = (opcode == OP_MOVI);
  assign is_alu  = (opcode >= OPC_W'(4'h2)) && (opcode <= OPC_W'(4'h7));
  assign is_alui = (opcode >= OPC_W'(4'hA)) && (opcode <= OPC_W'(4'hE));
  assign is_halt = (opcode == OP_HALT);
  assign ri_bad  = int'(ri) >= NUM_REGS;
  assign rj_bad  = int'(rj) >= NUM_REGS;

  // Rj is only range-checked where it names a register; for MOVI/ALUI it is an immediate.
  assign dec_illegal = !(is_move || is_movi || is_alu || is_alui || is_halt) ||
                       (!is_halt && ri_bad) ||
                       ((is_move || is_alu) && rj_bad);

  assign mfc_expire = (state == S_F2) && !mfc && (wait_cnt == CNT_LAST);
  assign fsm_state  = state;

  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [FLD_W-1:0] idx);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(idx) == i) sel[i] = 1'b1;
    end
    return sel;
  endfunction

  // start and mfc are plain level inputs sampled on the clock edge: start is
  // only looked at in IDLE, mfc only in F2; there is no ready/ack back to the source.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_F1;
      S_F1:   state_nxt = S_F2;
      S_F2: begin
        if (mfc)             state_nxt = S_F3;
        else if (mfc_expire) state_nxt = S_ERR;
      end
      S_F3:   state_nxt = S_DEC;
      S_DEC: begin
        if (dec_illegal)  state_nxt = S_ERR;
        else if (is_halt) state_nxt = S_HLT;
        else if (is_move) state_nxt = S_MV;
        else if (is_movi) state_nxt = S_MI;
        else              state_nxt = S_A1;
      end
      S_MV:   state_nxt = S_F1;
      S_MI:   state_nxt = S_F1;
      S_A1:   state_nxt = S_A2;
      S_A2:   state_nxt = S_A3;
      S_A3:   state_nxt = S_F1;
      S_HLT:  state_nxt = S_HLT;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_F2 && !mfc) wait_cnt <= wait_cnt + CNT_W'(1);
      else                       wait_cnt <= '0;
      if (state == S_DEC && dec_illegal)            illegal   <= 1'b1;
      if (state == S_DEC && !dec_illegal && is_halt) halted   <= 1'b1;
      if (mfc_expire)                               bus_error <= 1'b1;
    end
  end

  always_comb begin
    pc_read       = 1'b0;
    pc_increment  = 1'b0;
    mar_write     = 1'b0;
    mar_mem_read  = 1'b0;
    mem_en        = 1'b0;
    mem_rw        = 1'b0;
    mdr_mem_write = 1'b0;
    mdr_read      = 1'b0;
    ir_write      = 1'b0;
    reg_read      = '0;
    reg_write     = '0;
    imm_en        = 1'b0;
    imm_out       = '0;
    alu_op        = 3'd0;
    alu_in1_we    = 1'b0;
    alu_in2_we    = 1'b0;
    alu_out_en    = 1'b0;
    instr_done    = 1'b0;
    case (state)
      S_F1: begin
        pc_read   = 1'b1;
        mar_write = 1'b1;
      end
      S_F2: begin
        mar_mem_read  = 1'b1;
        mem_en        = 1'b1;
        mem_rw        = 1'b1;
        mdr_mem_write = mfc;
      end
      S_F3: begin
        mdr_read     = 1'b1;
        ir_write     = 1'b1;
        pc_increment = 1'b1;
      end
      S_MV: begin
        reg_read   = reg_sel(rj);
        reg_write  = reg_sel(ri);
        instr_done = 1'b1;
      end
      S_MI: begin
        imm_en     = 1'b1;
        imm_out    = imm_val;
        reg_write  = reg_sel(ri);
        instr_done = 1'b1;
      end
      S_A1: begin
        reg_read   = reg_sel(ri);
        alu_in1_we = 1'b1;
        alu_op     = opcode[2:0];
      end
      S_A2: begin
        // ALUI opcodes all have the top opcode bit set; ALU opcodes never do.
        if (opcode[OPC_W-1]) begin
          imm_en  = 1'b1;
          imm_out = imm_val;
        end else begin
          reg_read = reg_sel(rj);
        end
        alu_in2_we = 1'b1;
        alu_op     = opcode[2:0];
      end
      S_A3: begin
        alu_out_en = 1'b1;
        reg_write  = reg_sel(ri);
        alu_op     = opcode[2:0];
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed, table-driven bench for cpu_seq_ctrl: per-cycle expected output
// records plus hand-written timeout and mid-instruction reset sequences.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, mfc;
  logic [15:0] instr;
  logic        pc_read, pc_increment, mar_write, mar_mem_read, mem_en, mem_rw;
  logic        mdr_mem_write, mdr_read, ir_write;
  logic [3:0]  reg_read, reg_write;
  logic        imm_en;
  logic [15:0] imm_out;
  logic [2:0]  alu_op;
  logic        alu_in1_we, alu_in2_we, alu_out_en, instr_done;
  logic        halted, illegal, bus_error;
  logic [3:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic inv_en = 1'b0;

  typedef struct packed {
    logic pc_read, pc_increment, mar_write, mar_mem_read, mem_en, mem_rw;
    logic mdr_mem_write, mdr_read, ir_write;
    logic [3:0]  reg_read;
    logic [3:0]  reg_write;
    logic        imm_en;
    logic [15:0] imm_out;
    logic [2:0]  alu_op;
    logic alu_in1_we, alu_in2_we, alu_out_en, instr_done, halted, illegal, bus_error;
  } out_t;

  typedef struct {
    logic        rst;
    logic        st;
    logic        m;
    logic [15:0] ins;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  out_t act;

  cpu_seq_ctrl #(.DATA_W(16), .OPC_W(4), .NUM_REGS(4), .MFC_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .mfc(mfc),
    .pc_read(pc_read), .pc_increment(pc_increment), .mar_write(mar_write),
    .mar_mem_read(mar_mem_read), .mem_en(mem_en), .mem_rw(mem_rw),
    .mdr_mem_write(mdr_mem_write), .mdr_read(mdr_read), .ir_write(ir_write),
    .reg_read(reg_read), .reg_write(reg_write), .imm_en(imm_en), .imm_out(imm_out),
    .alu_op(alu_op), .alu_in1_we(alu_in1_we), .alu_in2_we(alu_in2_we),
    .alu_out_en(alu_out_en), .instr_done(instr_done), .halted(halted),
    .illegal(illegal), .bus_error(bus_error), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign act = {pc_read, pc_increment, mar_write, mar_mem_read, mem_en, mem_rw,
                mdr_mem_write, mdr_read, ir_write, reg_read, reg_write, imm_en,
                imm_out, alu_op, alu_in1_we, alu_in2_we, alu_out_en, instr_done,
                halted, illegal, bus_error};

  // expected-output builders, one per sequencer phase
  function automatic out_t o_zero();
    out_t o = '0;
    return o;
  endfunction
  function automatic out_t o_f1();
    out_t o = '0;
    o.pc_read = 1'b1; o.mar_write = 1'b1;
    return o;
  endfunction
  function automatic out_t o_f2(input logic m);
    out_t o = '0;
    o.mar_mem_read = 1'b1; o.mem_en = 1'b1; o.mem_rw = 1'b1; o.mdr_mem_write = m;
    return o;
  endfunction
  function automatic out_t o_f3();
    out_t o = '0;
    o.mdr_read = 1'b1; o.ir_write = 1'b1; o.pc_increment = 1'b1;
    return o;
  endfunction
  function automatic out_t o_mv(input logic [3:0] wr, input logic [3:0] rd);
    out_t o = '0;
    o.reg_write = wr; o.reg_read = rd; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic out_t o_mi(input logic [3:0] wr, input logic [15:0] imm);
    out_t o = '0;
    o.reg_write = wr; o.imm_en = 1'b1; o.imm_out = imm; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic out_t o_a1(input logic [3:0] rd, input logic [2:0] op);
    out_t o = '0;
    o.reg_read = rd; o.alu_in1_we = 1'b1; o.alu_op = op;
    return o;
  endfunction
  function automatic out_t o_a2(input logic [3:0] rd, input logic ie,
                                input logic [15:0] imm, input logic [2:0] op);
    out_t o = '0;
    o.reg_read = rd; o.imm_en = ie; o.imm_out = imm; o.alu_in2_we = 1'b1; o.alu_op = op;
    return o;
  endfunction
  function automatic out_t o_a3(input logic [3:0] wr, input logic [2:0] op);
    out_t o = '0;
    o.reg_write = wr; o.alu_out_en = 1'b1; o.alu_op = op; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic out_t o_hlt();
    out_t o = '0;
    o.halted = 1'b1;
    return o;
  endfunction
  function automatic out_t o_ill();
    out_t o = '0;
    o.illegal = 1'b1;
    return o;
  endfunction
  function automatic out_t o_bus();
    out_t o = '0;
    o.bus_error = 1'b1;
    return o;
  endfunction

  task automatic add(input logic r, input logic s, input logic m,
                     input logic [15:0] i, input out_t e);
    vec_t v;
    v.rst = r; v.st = s; v.m = m; v.ins = i; v.exp = e;
    vecs.push_back(v);
  endtask

  // fetch + decode rows with zero-wait memory
  task automatic add_fetch(input logic [15:0] i);
    add(0, 0, 1, i, o_f1());
    add(0, 0, 1, i, o_f2(1'b1));
    add(0, 0, 1, i, o_f3());
    add(0, 0, 1, i, o_zero());
  endtask

  // driver: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge
  task automatic step(input logic r, input logic s, input logic m, input logic [15:0] i);
    @(posedge clk);
    #1;
    reset = r; start = s; mfc = m; instr = i;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 16'h0000);
    step(1, 0, 0, 16'h0000);
  endtask

  task automatic check_out(input string name, input int idx, input out_t e);
    n_checks++;
    if (act !== e) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, e);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // bus exclusivity and one-hot register enables, every cycle
  always @(negedge clk) begin
    if (inv_en) begin
      int drivers;
      drivers = int'(pc_read) + int'(mdr_read) + int'(imm_en) + int'(alu_out_en)
              + $countones(reg_read);
      n_checks++;
      if (drivers > 1 || $countones(reg_read) > 1 || $countones(reg_write) > 1) begin
        n_errors++;
        $display("FAIL bus_invariant: drivers=%0d reg_read=%b reg_write=%b expected at most one",
                 drivers, reg_read, reg_write);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f2_at, err_at, c, done_at;
    reset = 1'b1; start = 1'b0; mfc = 1'b0; instr = 16'h0000;

    // MOVE R2<-R1
    add(0, 1, 1, 16'h0081, o_zero());
    add_fetch(16'h0081);
    add(0, 0, 1, 16'h0081, o_mv(4'b0100, 4'b0010));
    // MOVI R3<-5
    add_fetch(16'h10C5);
    add(0, 0, 1, 16'h10C5, o_mi(4'b1000, 16'h0005));
    // ALUI op2 R1, imm 3
    add_fetch(16'hA043);
    add(0, 0, 1, 16'hA043, o_a1(4'b0010, 3'd2));
    add(0, 0, 1, 16'hA043, o_a2(4'b0000, 1'b1, 16'h0003, 3'd2));
    add(0, 0, 1, 16'hA043, o_a3(4'b0010, 3'd2));
    // ALU op3 R1, R2
    add_fetch(16'h3042);
    add(0, 0, 1, 16'h3042, o_a1(4'b0010, 3'd3));
    add(0, 0, 1, 16'h3042, o_a2(4'b0100, 1'b0, 16'h0000, 3'd3));
    add(0, 0, 1, 16'h3042, o_a3(4'b0010, 3'd3));
    // ALUI op3 R1, largest immediate 63 (not range-checked)
    add_fetch(16'hB07F);
    add(0, 0, 1, 16'hB07F, o_a1(4'b0010, 3'd3));
    add(0, 0, 1, 16'hB07F, o_a2(4'b0000, 1'b1, 16'h003F, 3'd3));
    add(0, 0, 1, 16'hB07F, o_a3(4'b0010, 3'd3));
    // MOVE R0<-R3 with three MFC wait cycles
    add(0, 0, 0, 16'h0003, o_f1());
    add(0, 0, 0, 16'h0003, o_f2(1'b0));
    add(0, 0, 0, 16'h0003, o_f2(1'b0));
    add(0, 0, 0, 16'h0003, o_f2(1'b0));
    add(0, 0, 1, 16'h0003, o_f2(1'b1));
    add(0, 0, 1, 16'h0003, o_f3());
    add(0, 0, 1, 16'h0003, o_zero());
    add(0, 0, 1, 16'h0003, o_mv(4'b0001, 4'b1000));
    // HALT, then start must be ignored
    add_fetch(16'hF000);
    add(0, 1, 1, 16'hF000, o_hlt());
    add(0, 1, 1, 16'hF000, o_hlt());
    add(0, 0, 1, 16'hF000, o_hlt());
    // illegal opcode 0x8
    add(1, 0, 1, 16'h8000, o_hlt());
    add(0, 1, 1, 16'h8000, o_zero());
    add_fetch(16'h8000);
    add(0, 1, 1, 16'h8000, o_ill());
    add(0, 0, 1, 16'h8000, o_ill());
    // MOVE with Ri=5 out of range
    add(1, 0, 1, 16'h0141, o_ill());
    add(0, 1, 1, 16'h0141, o_zero());
    add_fetch(16'h0141);
    add(0, 0, 1, 16'h0141, o_ill());
    // ALU with Rj=5 out of range
    add(1, 0, 1, 16'h2045, o_ill());
    add(0, 1, 1, 16'h2045, o_zero());
    add_fetch(16'h2045);
    add(0, 0, 1, 16'h2045, o_ill());
    // illegal opcode 0x9
    add(1, 0, 1, 16'h9000, o_ill());
    add(0, 1, 1, 16'h9000, o_zero());
    add_fetch(16'h9000);
    add(0, 0, 1, 16'h9000, o_ill());
    add(1, 0, 1, 16'h0000, o_ill());
    add(0, 0, 1, 16'h0000, o_zero());

    do_reset();
    inv_en = 1'b1;
    check_out("reset_state", 0, o_zero());

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].m, vecs[i].ins);
      check_out("vec", i, vecs[i].exp);
    end

    // MFC timeout: bus_error exactly 15 cycles after F2 entry
    do_reset();
    step(0, 1, 0, 16'h0081);
    f2_at = -1; err_at = -1;
    for (c = 1; c <= 60; c++) begin
      step(0, 0, 0, 16'h0081);
      if (mem_en && f2_at < 0) f2_at = c;
      if (bus_error) begin
        err_at = c;
        break;
      end
    end
    check_int("timeout_f2_entry", f2_at, 2);
    check_int("timeout_latency", err_at - f2_at, 15);
    check_out("timeout_err", 0, o_bus());
    step(0, 1, 1, 16'h0081);
    check_out("timeout_err", 1, o_bus());
    step(0, 0, 1, 16'h0081);
    check_out("timeout_err", 2, o_bus());

    // reset asserted during A2, then a fresh fetch
    do_reset();
    step(0, 1, 1, 16'h3042);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 16'h3042);
    step(1, 0, 1, 16'h3042);
    check_out("mid_a2", 0, o_a2(4'b0100, 1'b0, 16'h0000, 3'd3));
    step(0, 1, 1, 16'h0081);
    check_out("after_reset", 0, o_zero());
    done_at = -1;
    for (c = 1; c <= 20; c++) begin
      step(0, 0, 1, 16'h0081);
      if (c == 1) check_out("refetch_f1", 0, o_f1());
      if (instr_done) begin
        done_at = c;
        check_out("refetch_retire", 0, o_mv(4'b0100, 4'b0010));
        break;
      end
    end
    check_int("refetch_latency", done_at, 5);

    inv_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
